// File: rtl/avalon_pio_gen.sv
// Avalon-MM parallel I/O slave: direction control, synchronised inputs,
// edge capture with masked interrupt, atomic set/clear of the output data.
module avalon_pio_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  localparam int unsigned DW = DATA_WIDTH;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("avalon_pio_gen: DATA_WIDTH must be 1..32");
  end

  if (EDGE_TYPE > 2) begin : g_bad_edge
    $error("avalon_pio_gen: EDGE_TYPE must be 0, 1 or 2");
  end

  if (IRQ_MODE > 1) begin : g_bad_irq
    $error("avalon_pio_gen: IRQ_MODE must be 0 or 1");
  end

  logic          wr_en;
  logic [DW-1:0] wd;

  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] dir_q,  dir_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [DW-1:0] edge_q, edge_d;
  logic [DW-1:0] meta_q, sync_q, prev_q;
  logic [DW-1:0] evt;
  logic [DW-1:0] clr;
  logic [DW-1:0] rd_v;

  logic unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[DW-1:0];
  assign unused_wd = ^writedata;

  // Edge event from the synchronised sample and its one-cycle history
  if (EDGE_TYPE == 0) begin : g_rise
    assign evt = sync_q & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign evt = ~sync_q & prev_q;
  end else begin : g_any
    assign evt = sync_q ^ prev_q;
  end

  // Write-1-to-clear mask; only live on a write to the edge register
  assign clr = (wr_en && address == A_EDGE) ? wd : '0;

  // Output data next state: plain load, atomic set or atomic clear
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      unique case (1'b1)
        (address == A_DATA): data_d = wd;
        (address == A_SET):  data_d = data_q | wd;
        (address == A_CLR):  data_d = data_q & ~wd;
        default:             data_d = data_q;
      endcase
    end
  end

  // Direction and interrupt mask are plain read/write registers
  always_comb begin
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr_en) begin
      unique case (1'b1)
        (address == A_DIR):  dir_d  = wd;
        (address == A_MASK): mask_d = wd;
        default: begin
          dir_d  = dir_q;
          mask_d = mask_q;
        end
      endcase
    end
  end

  // Sticky edge capture; a new event beats a same-cycle clear
  always_comb begin
    edge_d = (edge_q & ~clr) | evt;
  end

  // Register state and the input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE[DW-1:0];
      dir_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      meta_q <= in_port;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Zero-wait read mux; deselected or unmapped addresses read zero
  always_comb begin
    rd_v = '0;
    if (chipselect) begin
      unique case (1'b1)
        (address == A_DATA):
          rd_v = (dir_q & data_q) | (~dir_q & sync_q);
        (address == A_DIR):  rd_v = dir_q;
        (address == A_MASK): rd_v = mask_q;
        (address == A_EDGE): rd_v = edge_q;
        default:             rd_v = '0;
      endcase
    end
  end

  // Pad the bank width out to the 32-bit bus
  always_comb begin
    readdata         = '0;
    readdata[DW-1:0] = rd_v;
  end

  // Interrupt: captured edges, or live input levels on input pins
  if (IRQ_MODE == 1) begin : g_irq_edge
    assign irq = |(edge_q & mask_q);
  end else begin : g_irq_level
    assign irq = |(sync_q & mask_q & ~dir_q);
  end

  assign out_port = data_q;
  assign out_oe   = dir_q;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Bench for avalon_pio_gen: two configurations on a shared bus,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_avalon_pio_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs_a, cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a, out_a, oe_a;
  logic [31:0] in_b, out_b, oe_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  avalon_pio_gen #(
    .DATA_WIDTH (8),
    .RESET_VALUE(32'hA5),
    .EDGE_TYPE  (0),
    .IRQ_MODE   (1)
  ) u_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(cs_a),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_a),
    .in_port   (in_a),
    .out_port  (out_a),
    .out_oe    (oe_a),
    .irq       (irq_a)
  );

  avalon_pio_gen #(
    .DATA_WIDTH (32),
    .RESET_VALUE(32'h0),
    .EDGE_TYPE  (2),
    .IRQ_MODE   (0)
  ) u_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(cs_b),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_b),
    .in_port   (in_b),
    .out_port  (out_b),
    .out_oe    (oe_b),
    .irq       (irq_b)
  );

  localparam int RD_A = 0, OUT_A = 1, OE_A = 2, IRQ_A = 3;
  localparam int RD_B = 4, OUT_B = 5, OE_B = 6, IRQ_B = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      RD_A:    return rd_a;
      OUT_A:   return {24'h0, out_a};
      OE_A:    return {24'h0, oe_a};
      IRQ_A:   return {31'h0, irq_a};
      RD_B:    return rd_b;
      OUT_B:   return out_b;
      OE_B:    return oe_b;
      default: return {31'h0, irq_b};
    endcase
  endfunction

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c   = sbq.pop_front();
      act = pick(c.sel);
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", c.name, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string n, int sel, logic [31:0] v);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = v;
    sbq.push_back(c);
  endtask

  task automatic wr(int dut, logic [2:0] a, logic [31:0] d);
    cs_a      = (dut == 0);
    cs_b      = (dut == 1);
    address   = a;
    write_n   = 1'b0;
    writedata = d;
    tick();
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic rd(int dut, logic [2:0] a);
    cs_a    = (dut == 0);
    cs_b    = (dut == 1);
    address = a;
    write_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = '0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
    in_a      = '0;
    in_b      = '0;
    tick();
    expect_v("rst_out_a", OUT_A, 32'hA5);
    expect_v("rst_oe_a",  OE_A,  32'h0);
    expect_v("rst_irq_a", IRQ_A, 32'h0);
    expect_v("rst_out_b", OUT_B, 32'h0);
    expect_v("rst_oe_b",  OE_B,  32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // input sampling latency
    in_a = 8'h3C;
    tick();
    rd(0, 3'd0);
    expect_v("sync_1clk", RD_A, 32'h0);
    tick();
    expect_v("sync_2clk", RD_A, 32'h3C);
    tick();

    // direction-mixed data read
    wr(0, 3'd1, 32'h0F);
    wr(0, 3'd0, 32'h5A);
    expect_v("dir_out", OUT_A, 32'h5A);
    expect_v("dir_oe",  OE_A,  32'h0F);
    tick();
    in_a = 8'hC3;
    tick();
    tick();
    rd(0, 3'd0);
    expect_v("mixed_rd", RD_A, 32'hCA);
    tick();
    rd(0, 3'd3);
    expect_v("edge_ff",      RD_A,  32'hFF);
    expect_v("irq_unmasked", IRQ_A, 32'h0);
    tick();
    wr(0, 3'd3, 32'hFF);
    rd(0, 3'd3);
    expect_v("edge_clr_all", RD_A, 32'h0);
    tick();

    // atomic set and clear
    wr(0, 3'd0, 32'h10);
    wr(0, 3'd4, 32'h81);
    expect_v("outset", OUT_A, 32'h91);
    tick();
    wr(0, 3'd5, 32'h03);
    expect_v("outclear", OUT_A, 32'h90);
    tick();
    rd(0, 3'd4);
    expect_v("rd_outset", RD_A, 32'h0);
    tick();
    rd(0, 3'd5);
    expect_v("rd_outclr", RD_A, 32'h0);
    tick();

    // rising edge capture latency and irq
    wr(0, 3'd2, 32'h04);
    in_a = 8'hC7;
    tick();
    tick();
    rd(0, 3'd3);
    expect_v("edge_pre",    RD_A,  32'h0);
    expect_v("irq_pre",     IRQ_A, 32'h0);
    tick();
    rd(0, 3'd3);
    expect_v("edge_3rd",    RD_A,  32'h04);
    expect_v("irq_set",     IRQ_A, 32'h1);
    tick();
    in_a = 8'hC3;
    tick();
    tick();
    tick();
    rd(0, 3'd3);
    expect_v("fall_ignored", RD_A, 32'h04);
    tick();
    wr(0, 3'd3, 32'h04);
    rd(0, 3'd3);
    expect_v("w1c",     RD_A,  32'h0);
    expect_v("irq_clr", IRQ_A, 32'h0);
    tick();

    // clear collides with new event: set wins
    in_a = 8'hC7;
    tick();
    tick();
    wr(0, 3'd3, 32'h04);
    rd(0, 3'd3);
    expect_v("set_wins",     RD_A,  32'h04);
    expect_v("set_wins_irq", IRQ_A, 32'h1);
    tick();
    in_a = 8'hC3;
    tick();
    tick();
    tick();
    wr(0, 3'd3, 32'h04);

    // misc register reads on bank A
    rd(0, 3'd2);
    expect_v("rd_mask", RD_A, 32'h04);
    tick();
    cs_a    = 1'b0;
    address = 3'd1;
    expect_v("cs_low_a", RD_A, 32'h0);
    tick();
    wr(0, 3'd1, 32'hFFFF_FFFF);
    rd(0, 3'd1);
    expect_v("upper_zero", RD_A, 32'h0000_00FF);
    tick();

    // level irq on the 32-bit bank
    wr(1, 3'd2, 32'h8000_0000);
    in_b = 32'h8000_0000;
    tick();
    expect_v("lvl_1clk", IRQ_B, 32'h0);
    tick();
    expect_v("lvl_2clk", IRQ_B, 32'h1);
    tick();
    rd(1, 3'd3);
    expect_v("any_rise", RD_B, 32'h8000_0000);
    tick();
    wr(1, 3'd1, 32'h8000_0000);
    expect_v("lvl_outdir", IRQ_B, 32'h0);
    tick();
    rd(1, 3'd6);
    expect_v("rsvd6", RD_B, 32'h0);
    tick();
    rd(1, 3'd7);
    expect_v("rsvd7", RD_B, 32'h0);
    tick();
    wr(1, 3'd6, 32'hFFFF_FFFF);
    rd(1, 3'd1);
    expect_v("rsvd_wr_dir", RD_B, 32'h8000_0000);
    tick();
    rd(1, 3'd2);
    expect_v("rsvd_wr_mask", RD_B, 32'h8000_0000);
    tick();
    wr(1, 3'd3, 32'hFFFF_FFFF);
    in_b = 32'h0;
    tick();
    tick();
    tick();
    rd(1, 3'd3);
    expect_v("any_fall", RD_B, 32'h8000_0000);
    tick();
    cs_b    = 1'b0;
    address = 3'd3;
    expect_v("cs_low_b", RD_B, 32'h0);
    tick();
    wr(1, 3'd4, 32'h8000_0000);
    expect_v("b_outset", OUT_B, 32'h8000_0000);
    rd(1, 3'd0);
    expect_v("b_rd_data", RD_B, 32'h8000_0000);
    tick();

    tick();
    tick();
    if (sbq.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", sbq.size());
      failures += sbq.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gen.md
Name:
avalon_pio_gen

Overview:
Parametrised Avalon-MM slave parallel I/O block. It is the next generation of the team's fixed 8-bit output-only PIO.
- Adds per-bit direction control, synchronised input sampling and edge capture with an interrupt mask and one IRQ output.
- Adds atomic set and clear access to the output register.
- Sits on the system interconnect as one slave per GPIO bank (LEDs, switches, keys).

Parameters:
DATA_WIDTH, 8, number of I/O bits, legal 1..32.
RESET_VALUE, 0, reset value of the output data register (low DATA_WIDTH bits used).
EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
IRQ_MODE, 1, 0 level-sensitive, 1 edge-capture driven.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset, asynchronous, active-low.
address  in  3  register word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data.
readdata  out  32  read data, combinational, zero wait states.
in_port  in  DATA_WIDTH  external inputs, asynchronous to clk.
out_port  out  DATA_WIDTH  output data register.
out_oe  out  DATA_WIDTH  direction register; 1 means the bit is an output.
irq  out  1  interrupt request, active-high.

Behaviour:
Reset and clocking:
- reset, clk: reset reset_n, asynchronous, active-low; clock clk.
- All flops clear asynchronously on reset_n low and update only on posedge clk.
- Reset values: data_out = RESET_VALUE, direction = 0 (all inputs), irqmask = 0, edgecapture = 0, synchroniser and edge flops = 0.
- Consequences of reset: out_port = RESET_VALUE, out_oe = 0, irq = 0.

Register map (write = chipselect & ~write_n, applied at the next posedge):
- 0 data: write loads data_out <= writedata[DATA_WIDTH-1:0]. Read bit i = direction[i] ? data_out[i] : in_sync[i].
- 1 direction: read/write.
- 2 irqmask: read/write.
- 3 edgecapture: read returns edgecapture. Write is write-1-to-clear per bit.
- 4 outset: write does data_out <= data_out | wd. Reads 0.
- 5 outclear: write does data_out <= data_out & ~wd. Reads 0.
- 6, 7: reserved. Reads 0, writes ignored.
- readdata[31:DATA_WIDTH] is always 0.
- readdata is a pure function of address and current register state. chipselect low returns 0.

Input path:
- 2-flop synchroniser: in_meta <= in_port, in_sync <= in_meta.
- in_prev <= in_sync.
- Edge events:
  - rising = in_sync & ~in_prev
  - falling = ~in_sync & in_prev
  - any = in_sync ^ in_prev
- An in_port change reaches in_sync after 2 clk edges.
- The edge event is visible in edgecapture 1 clk later, i.e. 3 edges after the in_port change.

Edge capture:
- Per bit: next = (edgecapture & ~clr) | event.
- clr = writedata bits on a write to address 3.
- Simultaneous clear and new edge on the same bit: set wins.
- Edges are captured regardless of direction and irqmask.

Interrupt:
- IRQ_MODE 1: irq = |(edgecapture & irqmask).
- IRQ_MODE 0: irq = |(in_sync & irqmask & ~direction).
- irq is combinational from registered state and has no extra latency beyond the register update.

Writes and width:
- Each write affects only its addressed register. No partial byte enables.
- Writes to data, outset and outclear update out_port on the posedge of the write.
- DATA_WIDTH outside 1..32 is a compile-time error (generate-time check).

Test Plan:
- Reset with RESET_VALUE = 8'hA5 -> out_port = A5, out_oe = 00, irq = 0. Read addr 0 with in_port = 3C returns 0000003C after 2 clks.
- Write dir = 0F, then data = 5A -> out_port = 5A, out_oe = 0F. With in_port = C3, read addr 0 = 000000CA.
- outset 81 then outclear 03 from data_out = 10 -> data_out 91, then 90. Reads of addr 4 and 5 = 0.
- EDGE_TYPE 0, irqmask = 04: pulse in_port[2] low-high-low, 4 clks -> edgecapture = 04 on the 3rd edge after the rise, irq = 1. Write 04 to addr 3 -> edgecapture = 0, irq = 0.
- Clear of bit 2 in the same cycle a new rising event on bit 2 is captured -> edgecapture[2] stays 1.
- IRQ_MODE 0, DATA_WIDTH = 32, irqmask = 80000000: in_port[31] = 1 -> irq = 1 after 2 clks. Set direction[31] = 1 -> irq = 0. Addresses 6 and 7 read 0.
